// File: rtl/mme_pkg.sv
// Shared constants, state encoding and lane packing helper for the MME
// result path.
package mme_pkg;

  localparam int DEF_AW   = 6;
  localparam int DEF_DW   = 32;
  localparam int DEF_SIZE = 4;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  // Lane 0 sits in the most significant element of a packed row.
  function automatic int lane_slice(input int j,
                                    input int dw   = DEF_DW,
                                    input int size = DEF_SIZE);
    return dw * (size - 1 - j);
  endfunction

endpackage

// File: rtl/delay_line.sv
// DEPTH-stage W-bit shift register with synchronous clear.
// DEPTH=0 degenerates to a combinational pass-through.
module delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  // One dummy stage keeps the array legal when DEPTH=0; it is never selected.
  localparam int NST = (DEPTH == 0) ? 1 : DEPTH;

  logic [W-1:0] stage_q [NST];
  logic [W-1:0] stage_d [NST];

  always_comb begin
    stage_d[0] = din_i;
    for (int i = 1; i < NST; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NST; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout_o = (DEPTH == 0) ? din_i : stage_q[NST-1];

endmodule

// File: rtl/result_collector.sv
// De-skews the per-column systolic array result stream into whole rows and
// writes one packed row per SRAM word at consecutive addresses from 0.
module result_collector
  import mme_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int SIZE = DEF_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           matrix_width_i,
  input  logic                 start_i,
  output logic                 done_o,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] c_i [SIZE],
  output logic [AW-1:0]        sram_addr_o,
  output logic [DW*SIZE-1:0]   sram_wdata_o,
  output logic                 sram_we_o
);

  state_e state_q, state_d;
  logic [7:0] width_q, width_d;
  logic [7:0] acc_cnt_q, acc_cnt_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic       we_q, we_d;
  logic       last_q, last_d;
  logic       done_q, done_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW*SIZE-1:0] wdata_q, wdata_d;

  logic               accept;
  logic               aligned_v;
  logic [DW-1:0]      lane_dly [SIZE];
  logic [DW*SIZE-1:0] row;

  assign accept = (state_q == S_BUSY) && valid_i && (acc_cnt_q < width_q);

  // Lane j arrives j cycles after lane 0, so it needs SIZE-1-j stages to line up.
  for (genvar j = 0; j < SIZE; j++) begin : g_lane
    delay_line #(
      .W     (DW),
      .DEPTH (SIZE - 1 - j)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .din_i  (c_i[j]),
      .dout_o (lane_dly[j])
    );
  end

  delay_line #(
    .W     (1),
    .DEPTH (SIZE - 1)
  ) u_valid (
    .clk    (clk),
    .rst    (rst),
    .din_i  (accept),
    .dout_o (aligned_v)
  );

  always_comb begin
    row = '0;
    for (int j = 0; j < SIZE; j++) begin
      row[lane_slice(j, DW, SIZE) +: DW] = lane_dly[j];
    end
  end

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    we_d      = 1'b0;
    last_d    = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_BUSY;
          width_d   = matrix_width_i;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
        end
      end
      S_BUSY: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 8'd1;
        end
        if (aligned_v) begin
          we_d     = 1'b1;
          addr_d   = wr_cnt_q[AW-1:0];
          wdata_d  = row;
          wr_cnt_d = wr_cnt_q + 8'd1;
          last_d   = (wr_cnt_q == width_q - 8'd1);
        end
        // Leave one cycle after the final strobe so done rises after it.
        if ((width_q == 8'd0) || last_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      width_q   <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      we_q      <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      we_q      <= we_d;
      last_q    <= last_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign done_o       = done_q;
  assign sram_we_o    = we_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;

endmodule

// File: tb/tb_result_collector.sv
// Randomised and directed bench for result_collector against a timeline model:
// each accepted row is scheduled to appear SIZE cycles after its valid pulse.
module tb_result_collector;

  localparam int SIZE = 4;
  localparam int DW   = 32;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic valid_i = 1'b0;
  logic [7:0] matrix_width_i = 8'd0;
  logic signed [DW-1:0] c_i [SIZE];

  logic                 done_a, we_a, done_b, we_b;
  logic [5:0]           addr_a;
  logic [1:0]           addr_b;
  logic [DW*SIZE-1:0]   wdata_a, wdata_b;

  result_collector #(.AW(6), .DW(DW), .SIZE(SIZE)) dut_a (
    .clk            (clk),
    .rst            (rst),
    .matrix_width_i (matrix_width_i),
    .start_i        (start_i),
    .done_o         (done_a),
    .valid_i        (valid_i),
    .c_i            (c_i),
    .sram_addr_o    (addr_a),
    .sram_wdata_o   (wdata_a),
    .sram_we_o      (we_a)
  );

  // Narrow-address copy on the same stimulus exercises address wrap.
  result_collector #(.AW(2), .DW(DW), .SIZE(SIZE)) dut_b (
    .clk            (clk),
    .rst            (rst),
    .matrix_width_i (matrix_width_i),
    .start_i        (start_i),
    .done_o         (done_b),
    .valid_i        (valid_i),
    .c_i            (c_i),
    .sram_addr_o    (addr_b),
    .sram_wdata_o   (wdata_b),
    .sram_we_o      (we_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  // Reference model state: current busy flag, latched width, accepted rows,
  // and a schedule of row writes keyed by the cycle they must appear.
  bit          known = 1'b0;
  bit          m_busy = 1'b0;
  int          m_width = 0;
  int          m_acc = 0;
  bit          sv    [MAXC];
  int          srank [MAXC];
  int          ssrc  [MAXC];
  logic [31:0] hist  [MAXC][SIZE];
  bit           e_we = 1'b0;
  bit           e_done = 1'b1;
  int           e_rank = 0;
  logic [127:0] e_data = '0;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [7:0] w, input logic v,
                               input logic [31:0] l0, input logic [31:0] l1,
                               input logic [31:0] l2, input logic [31:0] l3);
    logic [31:0]  ln [SIZE];
    logic [127:0] word;
    bit           wr_now;
    int           wr_rank;
    @(negedge clk);
    if (known) begin
      checkOutput("we_a",    128'(we_a),    128'(e_we));
      checkOutput("we_b",    128'(we_b),    128'(e_we));
      checkOutput("addr_a",  128'(addr_a),  128'(e_rank % 64));
      checkOutput("addr_b",  128'(addr_b),  128'(e_rank % 4));
      checkOutput("wdata_a", wdata_a,       e_data);
      checkOutput("wdata_b", wdata_b,       e_data);
      checkOutput("done_a",  128'(done_a),  128'(e_done));
      checkOutput("done_b",  128'(done_b),  128'(e_done));
    end
    if (cyc + SIZE + 2 >= MAXC) begin
      $display("[TB] FAIL model_capacity: cycle %0d exceeds %0d", cyc, MAXC);
      $fatal(1, "[TB] out of model space");
    end
    rst = r; start_i = s; matrix_width_i = w; valid_i = v;
    ln[0] = l0; ln[1] = l1; ln[2] = l2; ln[3] = l3;
    for (int j = 0; j < SIZE; j++) begin
      c_i[j] = ln[j];
      hist[cyc][j] = ln[j];
    end
    wr_now  = sv[cyc];
    wr_rank = srank[cyc];
    if (r) begin
      m_busy = 1'b0;
      for (int k = cyc + 1; k <= cyc + SIZE; k++) sv[k] = 1'b0;
      e_we = 1'b0; e_rank = 0; e_data = '0;
      known = 1'b1;
    end else begin
      if (m_busy && v && (m_acc < m_width)) begin
        sv[cyc+SIZE]    = 1'b1;
        srank[cyc+SIZE] = m_acc;
        ssrc[cyc+SIZE]  = cyc;
        m_acc++;
      end
      if (m_busy) begin
        if (m_width == 0 || (wr_now && wr_rank == m_width - 1)) m_busy = 1'b0;
      end else if (s) begin
        m_busy = 1'b1; m_width = int'(w); m_acc = 0;
      end
      if (sv[cyc+1]) begin
        e_we = 1'b1;
        e_rank = srank[cyc+1];
        word = '0;
        for (int j = 0; j < SIZE; j++) word = (word << DW) | 128'(hist[ssrc[cyc+1]+j][j]);
        e_data = word;
      end else begin
        e_we = 1'b0;
      end
    end
    e_done = !m_busy;
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic startRun(input logic [7:0] w);
    applyStimulus(0, 1, w, 0, $urandom, $urandom, $urandom, $urandom);
  endtask

  // Pattern '1' marks a lane-0 valid; lane j of row k follows j cycles later.
  // mode 0: base+16k+j, mode 1: alternating -1 / 0x80000000, mode 2: random.
  task automatic playPattern(input string pat, input int mode, input logic [31:0] base, input int rst_at);
    int len;
    int src;
    int k;
    logic [31:0] ln [SIZE];
    len = pat.len();
    for (int i = 0; i < len + SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        src = i - j;
        ln[j] = $urandom;
        if (src >= 0 && src < len && pat[src] == "1") begin
          k = 0;
          for (int q = 0; q < src; q++) if (pat[q] == "1") k++;
          if (mode == 0)      ln[j] = base + 32'(16 * k + j);
          else if (mode == 1) ln[j] = ((k + j) % 2 != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        end
      end
      applyStimulus(i == rst_at, 0, 0, (i < len && pat[i] == "1"), ln[0], ln[1], ln[2], ln[3]);
    end
  endtask

  task automatic drainRun();
    int guard = 0;
    while (m_busy && guard < 400) begin
      applyStimulus(0, 0, 0, 1, $urandom, $urandom, $urandom, $urandom);
      guard++;
    end
    idleCycles(SIZE + 2);
    checkOutput("drain_done_a", 128'(done_a), 128'(1));
  endtask

  initial begin
    string pat;
    int    rst_at;
    for (int j = 0; j < SIZE; j++) c_i[j] = '0;
    $display("[TB] result_collector bench starting");

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(2);

    startRun(8'd1);
    playPattern("1", 0, 32'd1, -1);
    idleCycles(3);

    startRun(8'd8);
    playPattern("11111111", 0, 32'd0, -1);
    idleCycles(3);

    startRun(8'd3);
    playPattern("1010011", 0, 32'h100, -1);
    idleCycles(4);

    startRun(8'd5);
    playPattern("11111", 1, 32'd0, -1);
    idleCycles(3);

    startRun(8'd6);
    playPattern("1110000000", 0, 32'h200, 4);
    idleCycles(2);
    startRun(8'd2);
    playPattern("11", 0, 32'h300, -1);
    idleCycles(3);

    startRun(8'd0);
    idleCycles(3);
    startRun(8'd2);
    startRun(8'd7);
    playPattern("1111", 0, 32'h400, -1);
    idleCycles(3);
    playPattern("111", 0, 32'h500, -1);
    applyStimulus(0, 1, 8'd1, 1, $urandom, $urandom, $urandom, $urandom);
    playPattern("1", 0, 32'h600, -1);
    idleCycles(3);

    for (int run = 0; run < 12; run++) begin
      startRun(8'($urandom_range(0, 12)));
      pat = "";
      for (int i = 0; i < int'($urandom_range(0, 16)); i++)
        pat = {pat, ($urandom_range(0, 2) != 0) ? "1" : "0"};
      rst_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, pat.len() + 3)) : -1;
      playPattern(pat, 2, 32'd0, rst_at);
      drainRun();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
